// File: rtl/ifu_axi_pkg.sv
// rtl/ifu_axi_pkg.sv - shared types and widths for the IFU AXI-lite fetch path
package ifu_axi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/ifu_axi_fetch.sv
// rtl/ifu_axi_fetch.sv - single-outstanding AXI-lite instruction fetch initiator with flush
module ifu_axi_fetch #(
  parameter int ADDR_W = ifu_axi_pkg::ADDR_W,
  parameter int DATA_W = ifu_axi_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [63:0]       req_pc,
  input  logic              flush,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [63:0]       inst_pc,
  output logic              inst_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  input  logic              rresp
);

  import ifu_axi_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] araddr_d;
  logic              arvalid_d, rready_d;
  logic              inst_valid_d, inst_err_d;
  logic [INST_W-1:0] inst_d;
  logic [63:0]       inst_pc_d;

  // A new PC is only taken when nothing is outstanding and no flush is pending.
  assign req_ready = (state_q == IDLE) && !flush;

  // Next-state and next-register values; every register holds unless a handshake moves it.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    araddr_d     = araddr;
    arvalid_d    = arvalid;
    rready_d     = rready;
    inst_valid_d = inst_valid;
    inst_d       = inst;
    inst_pc_d    = inst_pc;
    inst_err_d   = inst_err;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          pc_d      = req_pc;
          araddr_d  = req_pc[ADDR_W-1:0];
          arvalid_d = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        // arvalid cannot be withdrawn, so a flush only marks the beat for discard.
        if (flush) drop_d = 1'b1;
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (rvalid) begin
          rready_d = 1'b0;
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            inst_d       = pc_q[2] ? rdata[2*INST_W-1:INST_W] : rdata[INST_W-1:0];
            inst_pc_d    = pc_q;
            inst_err_d   = rresp;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (flush || inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and all registered outputs; reset abandons any transaction immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      drop_q     <= 1'b0;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      araddr     <= araddr_d;
      arvalid    <= arvalid_d;
      rready     <= rready_d;
      inst_valid <= inst_valid_d;
      inst       <= inst_d;
      inst_pc    <= inst_pc_d;
      inst_err   <= inst_err_d;
    end
  end

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// tb/tb_ifu_axi_fetch.sv - scoreboard bench for ifu_axi_fetch with AXI-lite slave model
module tb_ifu_axi_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_pc = '0;
  logic        flush = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [63:0] rdata = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        rresp = 1'b0;

  always #5 clk = ~clk;

  ifu_axi_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc), .flush(flush),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_err(inst_err), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rresp(rresp)
  );

  localparam int M_NONE = 0, M_ADDR = 1, M_DATA = 2, M_HOLD = 3, M_RST = 4;

  int n_vec = 0, n_fail = 0;
  int cyc = 0, last_acc = 0, hs_cyc = 0, n_ar = 0, n_r = 0;

  bit          rnd = 1'b0, fixed_en = 1'b0, err_en = 1'b0;
  logic        err_val = 1'b0;
  logic [63:0] fixed_data = '0;
  int          ar_stall = 0, r_stall = 0, ready_hold = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory contents seen by the slave: one 64-bit line per 8-byte aligned address.
  function automatic logic [63:0] mem64(logic [31:0] a);
    logic [31:0] aw;
    aw = {a[31:3], 3'b000};
    if (fixed_en) return fixed_data;
    return {aw ^ 32'hC0DE_5A5A, (aw * 32'd2654435761) + 32'h13};
  endfunction

  function automatic logic slave_err(logic [31:0] a);
    if (err_en) return err_val;
    return a[4] ^ a[9];
  endfunction

  // Reference: the instruction at a PC is the 32-bit word at that byte address.
  function automatic exp_t ref_fetch(logic [63:0] pc);
    exp_t        r;
    logic [63:0] line;
    line  = mem64(pc[31:0]);
    r.inst = (pc[2]) ? line[63:32] : line[31:0];
    r.pc   = pc;
    r.err  = slave_err(pc[31:0]);
    return r;
  endfunction

  // AXI-lite read slave with protocol checks on the master side.
  initial begin
    logic [31:0] pend = '0, prev_addr = '0;
    bit          have = 0, ar_hs, r_hs, prev_pend = 0;
    int          dly = 0, ar_seen = 0;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      if (rst_n) begin
        if (prev_pend) begin
          check("arvalid_hold", arvalid, 1);
          check("araddr_stable", araddr, prev_addr);
        end
        if (arvalid) check("one_outstanding", have || rvalid, 0);
        prev_pend = arvalid && !arready;
        prev_addr = araddr;
        if (ar_hs) begin pend = araddr; n_ar++; end
        if (r_hs) n_r++;
      end else begin
        prev_pend = 0;
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        have = 0; rvalid = 0; arready = 0; ar_seen = 0;
      end else begin
        if (r_hs) rvalid = 0;
        if (ar_hs) begin
          have = 1; ar_seen = 0;
          dly = rnd ? int'($urandom_range(0, 3)) : r_stall;
        end else if (arvalid) ar_seen++;
        else ar_seen = 0;
        arready = rnd ? ($urandom_range(0, 2) != 0) : (ar_seen > ar_stall);
        if (have && !rvalid) begin
          if (dly == 0) begin
            rvalid = 1; rdata = mem64(pend); rresp = slave_err(pend); have = 0;
          end else dly--;
        end
      end
    end
  end

  // Decode stage: consumes instructions after ready_hold cycles or at random.
  initial begin
    int h = 0;
    forever begin
      tick();
      if (inst_valid) begin
        inst_ready = rnd ? ($urandom_range(0, 1) == 1) : (h >= ready_hold);
        h++;
      end else begin
        inst_ready = 0; h = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every consumed instruction and checks hold stability.
  initial begin
    exp_t        e;
    bit          pv = 0;
    logic [31:0] pi = '0;
    logic [63:0] pp = '0;
    logic        pe = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) pv = 0;
      else begin
        if (pv) begin
          check("inst_valid_hold", inst_valid, 1);
          check("inst_stable", inst, pi);
          check("inst_pc_stable", inst_pc, pp);
          check("inst_err_stable", inst_err, pe);
        end
        if (inst_valid && inst_ready && !flush) begin
          hs_cyc = cyc;
          if (exp_q.size() == 0) check("unexpected_inst", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            check("inst", inst, e.inst);
            check("inst_pc", inst_pc, e.pc);
            check("inst_err", inst_err, e.err);
          end
        end
        pv = inst_valid && !(inst_ready || flush);
        pi = inst; pp = inst_pc; pe = inst_err;
      end
    end
  end

  task automatic fetch(logic [63:0] pc, int mode);
    int n = 0;
    req_valid = 1; req_pc = pc;
    while (!req_ready && n < 100) begin tick(); n++; end
    check("req_accept_timeout", req_ready, 1);
    if (!req_ready) begin req_valid = 0; return; end
    last_acc = cyc;
    if (mode == M_NONE) exp_q.push_back(ref_fetch(pc));
    tick();
    req_valid = 0;
    if (mode == M_NONE || mode == M_RST) return;
    n = 0;
    if (mode == M_DATA) while (!rready && n < 100) begin tick(); n++; end
    if (mode == M_HOLD) while (!inst_valid && n < 100) begin tick(); n++; end
    flush = 1;
    tick();
    flush = 0;
    n = 0;
    while (!req_ready && n < 100) begin
      check("flushed_no_inst", inst_valid, 0);
      tick(); n++;
    end
    check("flush_idle_timeout", req_ready, 1);
  endtask

  task automatic expect_latency(string name, int lat);
    int n = 0;
    while (!inst_valid && n < 100) begin tick(); n++; end
    check(name, cyc - last_acc, lat);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 300) begin tick(); n++; end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_araddr", araddr, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_inst_err", inst_err, 0);
    rst_n = 1;
    #1;
    check("rst_req_ready", req_ready, 1);
    tick();

    fixed_en = 1; fixed_data = 64'h1111_2222_0000_0413; err_en = 1; err_val = 0;
    fetch(64'h8000_0000, M_NONE);
    expect_latency("lat_zero_wait", 3);
    drain();
    fetch(64'h8000_0004, M_NONE);
    expect_latency("lat_upper_word", 3);
    drain();
    fixed_en = 0; err_en = 0;

    ar_stall = 3; r_stall = 2;
    fetch(64'h0000_0000_1000_0010, M_NONE);
    expect_latency("lat_wait_states", 8);
    drain();

    r_stall = 1;
    fetch(64'h2000_0040, M_ADDR);
    drain();
    check("flush_addr_beat_taken", n_r, n_ar);
    ar_stall = 0; r_stall = 0;

    err_en = 1; err_val = 1; ready_hold = 5;
    fetch(64'h3000_0008, M_NONE);
    fetch(64'h3000_0104, M_NONE);
    check("b2b_accept_cycle", last_acc, hs_cyc + 1);
    drain();
    ready_hold = 0; err_en = 0;

    r_stall = 2;
    fetch(64'h5000_0020, M_DATA);
    fetch(64'h5000_0024, M_HOLD);
    fetch(64'h5000_0028, M_NONE);
    drain();
    r_stall = 0;

    rnd = 1;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      fetch({$urandom, $urandom}, (r < 7) ? M_NONE : 1 + (r % 3));
    end
    rnd = 0;
    drain();
    check("beats_match_ars", n_r, n_ar);

    r_stall = 6;
    fetch(64'h4000_0000, M_RST);
    r = 0;
    while (!rready && r < 100) begin tick(); r++; end
    check("rst_reach_data", rready, 1);
    #2;
    rst_n = 0;
    #1;
    check("async_arvalid", arvalid, 0);
    check("async_rready", rready, 0);
    check("async_inst_valid", inst_valid, 0);
    tick();
    tick();
    rst_n = 1;
    #1;
    check("async_req_ready", req_ready, 1);
    r_stall = 0;
    tick();
    fetch(64'h4000_0104, M_NONE);
    expect_latency("lat_after_reset", 3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
